// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: main register plus a skid entry behind a valid/ready handshake on both sides.
// Optional writeback forwarding into captured and held operands is enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef ID_EX_FWD_EN
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
`endif
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_rd_a,
    input  logic [DATA_W-1:0] id_rd_b,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_use_imm,
    input  logic              id_reg_wr,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic              ex_reg_wr,
    output logic [7:0]        stall_cnt
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t state, state_next;
    logic   accept, transfer;
    logic   load_main_in, load_main_skid, load_skid;

    logic              main_reg_wr;
    logic [DATA_W-1:0] skid_op_a, skid_op_b;
    logic [REG_AW-1:0] skid_rd;
    logic [OP_W-1:0]   skid_alu_op;
    logic              skid_reg_wr;

    logic [DATA_W-1:0] cap_a, cap_b, main_a_f, main_b_f, skid_a_f, skid_b_f;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_next = FULL;
                FULL: begin
                    if (accept && !transfer)      state_next = SKID;
                    else if (!accept && transfer) state_next = EMPTY;
                end
                SKID:    if (transfer) state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        ex_valid = (state != EMPTY);
        id_ready = (state != SKID);
    end

    assign accept         = id_valid & id_ready & ~flush;
    assign transfer       = ex_valid & ex_ready;
    assign load_main_in   = accept & ((state == EMPTY) | ((state == FULL) & transfer));
    assign load_skid      = accept & (state == FULL) & ~transfer;
    assign load_main_skid = (state == SKID) & transfer;
    assign ex_reg_wr      = main_reg_wr & ex_valid;

`ifdef ID_EX_FWD_EN
    logic [REG_AW-1:0] main_rs1, main_rs2, skid_rs1, skid_rs2;
    logic              main_use_imm, skid_use_imm;

    function automatic logic [DATA_W-1:0] fwd_op(input logic en, input logic [REG_AW-1:0] rs,
                                                 input logic [DATA_W-1:0] cur,
                                                 input logic wr, input logic [REG_AW-1:0] wrd,
                                                 input logic [DATA_W-1:0] wdata);
        return (en && wr && (wrd == rs)) ? wdata : cur;
    endfunction

    assign cap_a    = fwd_op(1'b1, id_rs1, id_rd_a, wb_wr_en, wb_rd, wb_data);
    assign cap_b    = id_use_imm ? id_imm_ext
                                 : fwd_op(1'b1, id_rs2, id_rd_b, wb_wr_en, wb_rd, wb_data);
    assign main_a_f = fwd_op(1'b1, main_rs1, ex_op_a, wb_wr_en, wb_rd, wb_data);
    assign main_b_f = fwd_op(~main_use_imm, main_rs2, ex_op_b, wb_wr_en, wb_rd, wb_data);
    assign skid_a_f = fwd_op(1'b1, skid_rs1, skid_op_a, wb_wr_en, wb_rd, wb_data);
    assign skid_b_f = fwd_op(~skid_use_imm, skid_rs2, skid_op_b, wb_wr_en, wb_rd, wb_data);

    // Source indices follow their beat so held operands can still be matched against writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_rs1 <= '0; main_rs2 <= '0; main_use_imm <= 1'b0;
            skid_rs1 <= '0; skid_rs2 <= '0; skid_use_imm <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_rs1 <= id_rs1; main_rs2 <= id_rs2; main_use_imm <= id_use_imm;
            end else if (load_main_skid) begin
                main_rs1 <= skid_rs1; main_rs2 <= skid_rs2; main_use_imm <= skid_use_imm;
            end
            if (load_skid) begin
                skid_rs1 <= id_rs1; skid_rs2 <= id_rs2; skid_use_imm <= id_use_imm;
            end
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{id_rs1, id_rs2};
    assign cap_a     = id_rd_a;
    assign cap_b     = id_use_imm ? id_imm_ext : id_rd_b;
    assign main_a_f  = ex_op_a;
    assign main_b_f  = ex_op_b;
    assign skid_a_f  = skid_op_a;
    assign skid_b_f  = skid_op_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op_a <= '0; ex_op_b <= '0; ex_rd <= '0; ex_alu_op <= '0; main_reg_wr <= 1'b0;
        end else if (load_main_in) begin
            ex_op_a <= cap_a; ex_op_b <= cap_b; ex_rd <= id_rd;
            ex_alu_op <= id_alu_op; main_reg_wr <= id_reg_wr;
        end else if (load_main_skid) begin
            ex_op_a <= skid_a_f; ex_op_b <= skid_b_f; ex_rd <= skid_rd;
            ex_alu_op <= skid_alu_op; main_reg_wr <= skid_reg_wr;
        end else begin
            ex_op_a <= main_a_f; ex_op_b <= main_b_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_op_a <= '0; skid_op_b <= '0; skid_rd <= '0; skid_alu_op <= '0; skid_reg_wr <= 1'b0;
        end else if (load_skid) begin
            skid_op_a <= cap_a; skid_op_b <= cap_b; skid_rd <= id_rd;
            skid_alu_op <= id_alu_op; skid_reg_wr <= id_reg_wr;
        end else begin
            skid_op_a <= skid_a_f; skid_op_b <= skid_b_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       stall_cnt <= 8'd0;
        else if (ex_valid && !ex_ready) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, immediate mux, skid ordering, flush, stall saturation,
// back-to-back flow and (when ID_EX_FWD_EN is defined) writeback forwarding.
module tb_id_ex_stage;

    logic       clk, rst, flush;
    logic       id_valid, id_ready;
    logic [7:0] id_rd_a, id_rd_b, id_imm_ext;
    logic [2:0] id_rs1, id_rs2, id_rd, id_alu_op;
    logic       id_use_imm, id_reg_wr;
    logic       ex_valid, ex_ready;
    logic [7:0] ex_op_a, ex_op_b;
    logic [2:0] ex_rd, ex_alu_op;
    logic       ex_reg_wr;
    logic [7:0] stall_cnt;
`ifdef ID_EX_FWD_EN
    logic       wb_wr_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef ID_EX_FWD_EN
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rd_a(id_rd_a), .id_rd_b(id_rd_b), .id_imm_ext(id_imm_ext),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_use_imm(id_use_imm), .id_reg_wr(id_reg_wr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_reg_wr(ex_reg_wr), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                        input logic use_imm, input logic [2:0] rd, input logic [2:0] op,
                        input logic wr, input logic [2:0] rs1, input logic [2:0] rs2);
        id_valid = 1'b1; id_rd_a = a; id_rd_b = b; id_imm_ext = imm; id_use_imm = use_imm;
        id_rd = rd; id_alu_op = op; id_reg_wr = wr; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        beat(8'h0, 8'h0, 8'h0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        id_valid = 1'b0;
`ifdef ID_EX_FWD_EN
        wb_wr_en = 1'b0; wb_rd = 3'd0; wb_data = 8'h00;
`endif
        #12;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %0b want 0", ex_valid); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready: got %0b want 1", id_ready); end
        checks++; if ({ex_op_a, ex_op_b, ex_rd, ex_alu_op, ex_reg_wr} !== 23'd0) begin errors++;
            $display("FAIL rst_outputs: got a=%h b=%h rd=%0d op=%0d wr=%0b want all 0", ex_op_a, ex_op_b, ex_rd, ex_alu_op, ex_reg_wr); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        @(posedge clk); #1; rst = 1'b0;
        // Mid-run reset with a stalled beat held
        beat(8'h77, 8'h66, 8'h55, 1'b0, 3'd4, 3'd2, 1'b1, 3'd1, 3'd2);
        tick();
        id_valid = 1'b0;
        tick(); tick();
        checks++; if (ex_valid !== 1'b1 || stall_cnt !== 8'd2) begin errors++;
            $display("FAIL midrun_pre: got valid=%0b stall=%0d want valid=1 stall=2", ex_valid, stall_cnt); end
        #3 rst = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || stall_cnt !== 8'd0 ||
                      ex_op_a !== 8'h00 || ex_op_b !== 8'h00 || ex_reg_wr !== 1'b0) begin errors++;
            $display("FAIL midrun_rst: got valid=%0b ready=%0b stall=%0d a=%h b=%h wr=%0b want 0 1 0 00 00 0",
                     ex_valid, id_ready, stall_cnt, ex_op_a, ex_op_b, ex_reg_wr); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_imm_mux();
        ex_ready = 1'b1;
        beat(8'h11, 8'h22, 8'hFD, 1'b1, 3'd5, 3'd3, 1'b1, 3'd1, 3'd2);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op_a !== 8'h11 || ex_op_b !== 8'hFD) begin errors++;
            $display("FAIL imm_beat: got valid=%0b a=%h b=%h want 1 11 fd", ex_valid, ex_op_a, ex_op_b); end
        checks++; if (ex_rd !== 3'd5 || ex_alu_op !== 3'd3 || ex_reg_wr !== 1'b1) begin errors++;
            $display("FAIL imm_ctl: got rd=%0d op=%0d wr=%0b want 5 3 1", ex_rd, ex_alu_op, ex_reg_wr); end
        beat(8'h33, 8'h44, 8'hFD, 1'b0, 3'd6, 3'd1, 1'b0, 3'd1, 3'd2);
        tick();
        checks++; if (ex_op_a !== 8'h33 || ex_op_b !== 8'h44 || ex_reg_wr !== 1'b0) begin errors++;
            $display("FAIL reg_beat: got a=%h b=%h wr=%0b want 33 44 0", ex_op_a, ex_op_b, ex_reg_wr); end
        id_valid = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_wr !== 1'b0) begin errors++;
            $display("FAIL imm_drain: got valid=%0b wr=%0b want 0 0", ex_valid, ex_reg_wr); end
    endtask

    task automatic test_skid();
        ex_ready = 1'b0;
        beat(8'hA1, 8'hA2, 8'h00, 1'b0, 3'd1, 3'd1, 1'b1, 3'd0, 3'd0);
        tick();
        checks++; if (ex_valid !== 1'b1 || id_ready !== 1'b1 || ex_op_a !== 8'hA1) begin errors++;
            $display("FAIL skid_a_full: got valid=%0b ready=%0b a=%h want 1 1 a1", ex_valid, id_ready, ex_op_a); end
        beat(8'hB1, 8'hB2, 8'h00, 1'b0, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0);
        tick();
        checks++; if (id_ready !== 1'b0 || ex_op_a !== 8'hA1 || ex_op_b !== 8'hA2 || ex_rd !== 3'd1) begin errors++;
            $display("FAIL skid_state: got ready=%0b a=%h b=%h rd=%0d want 0 a1 a2 1", id_ready, ex_op_a, ex_op_b, ex_rd); end
        beat(8'hC1, 8'hC2, 8'h00, 1'b0, 3'd3, 3'd3, 1'b1, 3'd0, 3'd0);
        tick();
        checks++; if (id_ready !== 1'b0 || ex_op_a !== 8'hA1) begin errors++;
            $display("FAIL skid_hold: got ready=%0b a=%h want 0 a1", id_ready, ex_op_a); end
        id_valid = 1'b0; ex_ready = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b1 || id_ready !== 1'b1 || ex_op_a !== 8'hB1 || ex_op_b !== 8'hB2 || ex_rd !== 3'd2) begin errors++;
            $display("FAIL skid_b_out: got valid=%0b ready=%0b a=%h b=%h rd=%0d want 1 1 b1 b2 2",
                     ex_valid, id_ready, ex_op_a, ex_op_b, ex_rd); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL skid_drain: got valid=%0b want 0 (beat C must not be taken)", ex_valid); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        beat(8'hD1, 8'hD2, 8'h00, 1'b0, 3'd1, 3'd1, 1'b1, 3'd0, 3'd0);
        tick();
        beat(8'hE1, 8'hE2, 8'h00, 1'b0, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0);
        tick();
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_pre: got ready=%0b want 0", id_ready); end
        beat(8'hF1, 8'hF2, 8'h00, 1'b0, 3'd3, 3'd3, 1'b1, 3'd0, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_reg_wr !== 1'b0) begin errors++;
            $display("FAIL flush_state: got valid=%0b ready=%0b wr=%0b want 0 1 0", ex_valid, id_ready, ex_reg_wr); end
        ex_ready = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL flush_dropped: got valid=%0b want 0", ex_valid); end
    endtask

    task automatic test_stall_sat();
        do_reset();
        ex_ready = 1'b0;
        beat(8'h5C, 8'h3E, 8'h00, 1'b0, 3'd7, 3'd5, 1'b1, 3'd0, 3'd0);
        tick();
        id_valid = 1'b0;
        repeat (10) tick();
        checks++; if (stall_cnt !== 8'd10) begin errors++; $display("FAIL stall_10: got %0d want 10", stall_cnt); end
        repeat (300) tick();
        checks++; if (stall_cnt !== 8'hFF) begin errors++; $display("FAIL stall_sat: got %h want ff", stall_cnt); end
        checks++; if (ex_valid !== 1'b1 || ex_op_a !== 8'h5C || ex_op_b !== 8'h3E || ex_rd !== 3'd7) begin errors++;
            $display("FAIL stall_stable: got valid=%0b a=%h b=%h rd=%0d want 1 5c 3e 7", ex_valid, ex_op_a, ex_op_b, ex_rd); end
        ex_ready = 1'b1;
        tick();
        checks++; if (stall_cnt !== 8'hFF || ex_valid !== 1'b0) begin errors++;
            $display("FAIL stall_after: got stall=%h valid=%0b want ff 0", stall_cnt, ex_valid); end
    endtask

    task automatic test_back_to_back();
        ex_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            beat(8'(i * 16), 8'(i), 8'h00, 1'b0, 3'(i), 3'(i), 1'b1, 3'd0, 3'd0);
            tick();
            checks++; if (ex_valid !== 1'b1 || id_ready !== 1'b1 || ex_op_a !== 8'(i * 16) || ex_rd !== 3'(i)) begin errors++;
                $display("FAIL b2b_%0d: got valid=%0b ready=%0b a=%h rd=%0d want 1 1 %h %0d",
                         i, ex_valid, id_ready, ex_op_a, ex_rd, 8'(i * 16), i); end
        end
        id_valid = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%0b want 0", ex_valid); end
    endtask

`ifdef ID_EX_FWD_EN
    task automatic test_fwd();
        ex_ready = 1'b0;
        beat(8'h10, 8'h20, 8'h00, 1'b0, 3'd1, 3'd0, 1'b1, 3'd3, 3'd4);
        tick();
        id_valid = 1'b0;
        wb_wr_en = 1'b1; wb_rd = 3'd3; wb_data = 8'h5A;
        tick();
        wb_wr_en = 1'b0;
        checks++; if (ex_op_a !== 8'h5A || ex_op_b !== 8'h20) begin errors++;
            $display("FAIL fwd_held: got a=%h b=%h want 5a 20", ex_op_a, ex_op_b); end
        ex_ready = 1'b1;
        beat(8'h10, 8'h20, 8'h00, 1'b0, 3'd1, 3'd0, 1'b1, 3'd3, 3'd4);
        wb_wr_en = 1'b1; wb_rd = 3'd4; wb_data = 8'hC3;
        tick();
        wb_wr_en = 1'b0; id_valid = 1'b0;
        checks++; if (ex_op_a !== 8'h10 || ex_op_b !== 8'hC3) begin errors++;
            $display("FAIL fwd_capture: got a=%h b=%h want 10 c3", ex_op_a, ex_op_b); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_imm_mux();
        test_skid();
        test_flush();
        test_stall_sat();
        test_back_to_back();
`ifdef ID_EX_FWD_EN
        test_fwd();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
